dma_rd_sched: RTL



---
 rtl/aix_dma_pkg.sv | 24 ++
 rtl/dma_rd_sched_if.sv | 35 +++
 rtl/dma_rd_sched_rr_arbiter.sv | 40 ++++
 rtl/dma_rd_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/aix_dma_pkg.sv
// Shared definitions for the DMA read scheduler slice.
// Contents: FSM state encoding, requester index constants, default
// word-count width and a helper for sizing index fields.
package aix_dma_pkg;

  localparam int unsigned BITS_TRANS_DEF = 18;

  // Requester slots on the scheduler's request vector
  localparam int unsigned REQ_WGT  = 0;
  localparam int unsigned REQ_BIAS = 1;
  localparam int unsigned REQ_IFM  = 2;

  // Scheduler FSM encoding (kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of an index into n requesters; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_rd_sched_if.sv
// Functional port between the read scheduler and the AXI read DMA engine.
// master: scheduler side (drives start/addr/len, receives data/valid/done)
// slave : DMA side
//   dma_start_o  one-cycle transfer start
//   dma_addr_o   start byte address
//   dma_len_o    number of 32-bit words
//   dma_data_i   returned word
//   dma_vld_i    returned word valid
//   dma_done_i   transfer complete (coincides with the last beat)
interface dma_rd_sched_if
  import aix_dma_pkg::*;
#(
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned AXI_WIDTH_DA = 32,
  parameter int unsigned BITS_TRANS   = BITS_TRANS_DEF
);

  logic                    dma_start_o;
  logic [AXI_WIDTH_AD-1:0] dma_addr_o;
  logic [BITS_TRANS-1:0]   dma_len_o;
  logic [AXI_WIDTH_DA-1:0] dma_data_i;
  logic                    dma_vld_i;
  logic                    dma_done_i;

  modport master (
    output dma_start_o, dma_addr_o, dma_len_o,
    input  dma_data_i, dma_vld_i, dma_done_i
  );

  modport slave (
    input  dma_start_o, dma_addr_o, dma_len_o,
    output dma_data_i, dma_vld_i, dma_done_i
  );

endinterface

// File: rtl/dma_rd_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req  request vector
//   ptr  highest-priority index for this pick
//   gnt  one-hot grant of the first set request at or after ptr (wrapping)
//   idx  binary index of the winner
//   any  at least one request is set
module rr_arbiter
  import aix_dma_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                   = 1'b1;
        gnt[cand[IDX_W-1:0]]  = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_rd_sched.sv
// Round-robin scheduler sharing one AXI read DMA among NUM_REQ loaders
// (0 = weights, 1 = bias/scale, 2 = input feature map).
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   req_i         per-requester level request, held until done_o
//   req_addr_i    packed start addresses, slice k = requester k
//   req_len_i     packed word counts, slice k = requester k
//   gnt_o         one-hot grant, held for the whole transfer
//   rd_data_o     returned word (shared bus)
//   rd_vld_o      one-hot data valid, only while the DMA is streaming
//   done_o        one-cycle completion pulse for the granted requester
//   err_o         sticky beat-count mismatch flag
//   dma           functional port to the DMA engine
module dma_rd_sched
  import aix_dma_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned BITS_TRANS   = BITS_TRANS_DEF,
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned AXI_WIDTH_DA = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*AXI_WIDTH_AD-1:0] req_addr_i,
  input  logic [NUM_REQ*BITS_TRANS-1:0]   req_len_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [AXI_WIDTH_DA-1:0]         rd_data_o,
  output logic [NUM_REQ-1:0]              rd_vld_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            err_o,
  dma_rd_sched_if.master                  dma
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [1:0]              state;
  logic [IDX_W-1:0]        ptr;
  logic [BITS_TRANS-1:0]   beat_cnt;
  logic                    start_q;
  logic [AXI_WIDTH_AD-1:0] addr_q;
  logic [BITS_TRANS-1:0]   len_q;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic [IDX_W-1:0]        ptr_next;
  logic [AXI_WIDTH_AD-1:0] win_addr;
  logic [BITS_TRANS-1:0]   win_len;
  logic                    busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // The grant is one-hot, so the winner's fields are an AND-OR select
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        win_addr = win_addr | req_addr_i[k*AXI_WIDTH_AD +: AXI_WIDTH_AD];
        win_len  = win_len  | req_len_i[k*BITS_TRANS +: BITS_TRANS];
      end
    end
  end

  // Pointer moves just past the winner; with one requester it stays 0
  assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  assign busy      = (state == ST_BUSY);
  assign rd_data_o = dma.dma_data_i;
  assign rd_vld_o  = busy ? (gnt_o & {NUM_REQ{dma.dma_vld_i}}) : '0;

  assign dma.dma_start_o = start_q;
  assign dma.dma_addr_o  = addr_q;
  assign dma.dma_len_o   = len_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      start_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      gnt_o    <= '0;
      done_o   <= '0;
      err_o    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_o  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_o    <= arb_gnt;
            addr_q   <= win_addr;
            len_q    <= win_len;
            ptr      <= ptr_next;
            beat_cnt <= '0;
            // The DMA never completes a zero-length transfer, so skip it
            if (win_len == '0) begin
              state  <= ST_DONE;
              done_o <= arb_gnt;
            end else begin
              state   <= ST_START;
              start_q <= 1'b1;
            end
          end
        end
        ST_START: begin
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (dma.dma_vld_i) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (dma.dma_done_i) begin
            state  <= ST_DONE;
            done_o <= gnt_o;
            // Done arrives with the last beat, so that beat is not yet counted
            if ((beat_cnt + BITS_TRANS'(dma.dma_vld_i)) != len_q) begin
              err_o <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          gnt_o <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
